// File: rtl/io_mmio.sv
// io_mmio -- memory-mapped I/O block for a small core.
//
// Decodes addr[7:0] for I/O loads/stores (qualified upstream by io_trans /
// io_recv) and provides:
//   0x00 status     (R)  {30'b0, rx_nonempty, tx_empty}
//   0x04 RX data    (R)  pops the 4-entry receive FIFO; 0 when empty
//   0x08 TX data    (W)  loads the transmit holding register when free
//   0x10 cycle cnt  (R)  free-running 32-bit cycle counter
//   0x14 inst cnt   (R)  32-bit retired-instruction counter
//   0x18 cnt reset  (W)  clears both counters
//
// Ports:
//   clock, reset_n        clock, async active-low reset
//   addr, wdata           load/store address and lane-aligned store data
//   io_trans[3:0]         store byte strobes (any set = I/O write)
//   io_recv               I/O load request
//   inst_retired          one instruction retired this cycle
//   rdata                 registered load data (held until next io_recv)
//   tx_data/valid/ready   UART transmit handshake
//   rx_data/valid/ready   UART receive handshake
module io_mmio (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  io_trans,
  input  logic        io_recv,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  logic [7:0]  off;
  logic [7:0]  rx_mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  rx_cnt;
  logic [31:0] cyc_cnt, inst_cnt;
  logic [31:0] rd_mux;
  logic        tx_empty, rx_nonempty;
  logic        push, pop, tx_load, cnt_clr;
  logic        unused_bits;

  assign off         = addr[7:0];
  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  // The holding register is free exactly when nothing is being offered.
  assign tx_empty    = ~tx_valid;
  assign rx_nonempty = (rx_cnt != 3'd0);

  // Ready depends on count alone, so a full FIFO refuses a byte even in a
  // cycle where it is also being popped.
  assign rx_ready = (rx_cnt != 3'd4);
  assign push     = rx_valid & rx_ready;
  assign pop      = io_recv & (off == OFF_RX) & rx_nonempty;

  // tx_empty is the pre-handshake value: a write landing in the same cycle
  // as the handshake sees a busy register and is dropped.
  assign tx_load  = io_trans[0] & (off == OFF_TX) & tx_empty;
  assign cnt_clr  = (|io_trans) & (off == OFF_CLR);

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS: rd_mux = {30'b0, rx_nonempty, tx_empty};
      OFF_RX:     if (rx_nonempty) rd_mux = {24'b0, rx_mem[rd_ptr]};
      OFF_CYC:    rd_mux = cyc_cnt;
      OFF_INST:   rd_mux = inst_cnt;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rx_cnt   <= '0;
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      for (int i = 0; i < 4; i++) rx_mem[i] <= '0;
    end else begin
      if (io_recv) rdata <= rd_mux;

      if (tx_load) begin
        tx_valid <= 1'b1;
        tx_data  <= wdata[7:0];
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      if (push) begin
        rx_mem[wr_ptr] <= rx_data;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      rx_cnt <= rx_cnt + {2'b0, push} - {2'b0, pop};

      // Clear wins over the increment of the same cycle.
      if (cnt_clr) begin
        cyc_cnt  <= '0;
        inst_cnt <= '0;
      end else begin
        cyc_cnt  <= cyc_cnt + 32'd1;
        inst_cnt <= inst_cnt + {31'b0, inst_retired};
      end
    end
  end

endmodule

// File: tb/tb_io_mmio.sv
// tb_io_mmio -- directed + randomized bench for io_mmio. A transaction-level
// model (byte queue, pending-TX flag, integer counters) predicts every output.
module tb_io_mmio;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  io_trans;
  logic        io_recv, inst_retired;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [31:0] m_cyc, m_inst, m_rdata;
  logic        m_txv;
  logic [7:0]  m_txd;

  io_mmio dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .wdata(wdata),
    .io_trans(io_trans), .io_recv(io_recv), .inst_retired(inst_retired),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_inst = 0; m_rdata = 0; m_txv = 0; m_txd = 0;
  endtask

  task automatic idle();
    addr = 0; wdata = 0; io_trans = 0; io_recv = 0; inst_retired = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;
  endtask

  task automatic check_outputs();
    chk("rdata",    rdata,    m_rdata);
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_txv});
    chk("tx_data",  {24'b0, tx_data},  {24'b0, m_txd});
    chk("rx_ready", {31'b0, rx_ready}, {31'b0, (q.size() != 4)});
  endtask

  // One clock: predict from pre-edge inputs, advance, compare, go idle.
  task automatic cycle();
    logic [7:0]  a;
    logic [31:0] n_rd, n_cyc, n_inst;
    logic        n_txv, do_pop, do_push;
    logic [7:0]  n_txd;
    a = addr[7:0];
    n_rd = m_rdata;
    if (io_recv) begin
      if (a == 8'h00)      n_rd = {30'b0, q.size() > 0, !m_txv};
      else if (a == 8'h04) n_rd = (q.size() > 0) ? {24'b0, q[0]} : 32'd0;
      else if (a == 8'h10) n_rd = m_cyc;
      else if (a == 8'h14) n_rd = m_inst;
      else                 n_rd = 0;
    end
    do_pop  = io_recv && a == 8'h04 && q.size() > 0;
    do_push = rx_valid && q.size() < 4;
    n_txv = m_txv; n_txd = m_txd;
    if (!m_txv && io_trans[0] && a == 8'h08) begin
      n_txv = 1; n_txd = wdata[7:0];
    end else if (m_txv && tx_ready) begin
      n_txv = 0;
    end
    if (io_trans != 0 && a == 8'h18) begin
      n_cyc = 0; n_inst = 0;
    end else begin
      n_cyc = m_cyc + 1; n_inst = m_inst + (inst_retired ? 1 : 0);
    end
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(rx_data);
    @(posedge clock); #1;
    m_rdata = n_rd; m_txv = n_txv; m_txd = n_txd; m_cyc = n_cyc; m_inst = n_inst;
    check_outputs();
    idle();
  endtask

  task automatic rd(input logic [7:0] a);
    addr = {24'h0, a}; io_recv = 1; cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = {24'h0, a}; wdata = d; io_trans = 4'hF; cycle();
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1; rx_data = b; cycle();
  endtask

  // Reset pulse placed between edges; outputs must clear with no edge.
  task automatic mid_reset();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    #1 reset_n = 1;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    check_outputs();
    chk("reset_rdata", rdata, 32'd0);
    #6 reset_n = 1;

    // counters: 10 cycles, 6 retirements
    for (int i = 0; i < 10; i++) begin
      inst_retired = (i < 6);
      cycle();
    end
    rd(8'h10); chk("cyc10", rdata, 32'd10);
    rd(8'h14); chk("inst6", rdata, 32'd6);
    wr(8'h18, 0);
    rd(8'h10); chk("cyc_clr0", rdata, 32'd0);
    rd(8'h10); chk("cyc_clr1", rdata, 32'd1);

    // RX fill and drain
    for (int i = 0; i < 4; i++) push(8'h41 + i[7:0]);
    chk("rx_full_ready", {31'b0, rx_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(8'h04); chk("rx_order", rdata, 32'h41 + i);
    end
    rd(8'h04); chk("rx_empty_read", rdata, 32'd0);
    rd(8'h00); chk("status_idle", rdata, 32'h1);

    // TX hold and drop
    wr(8'h08, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("tx_hold_v", {31'b0, tx_valid}, 32'd1);
      chk("tx_hold_d", {24'b0, tx_data}, 32'h5A);
    end
    wr(8'h08, 32'hA5); chk("tx_drop", {24'b0, tx_data}, 32'h5A);
    tx_ready = 1; cycle(); chk("tx_done", {31'b0, tx_valid}, 32'd0);
    rd(8'h00); chk("status_tx_free", rdata, 32'h1);

    // write colliding with handshake is dropped
    wr(8'h08, 32'h11);
    tx_ready = 1; addr = 32'h08; wdata = 32'h22; io_trans = 4'h1; cycle();
    chk("tx_collide", {31'b0, tx_valid}, 32'd0);

    // full FIFO: push refused even while popping
    for (int i = 0; i < 4; i++) push(8'h01 + i[7:0]);
    rx_valid = 1; rx_data = 8'h99; addr = 32'h04; io_recv = 1; cycle();
    chk("full_pop", rdata, 32'h01);
    chk("full_pop_ready", {31'b0, rx_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd(8'h04); chk("full_drain", rdata, 32'h02 + i);
    end
    rd(8'h04); chk("full_no_store", rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      push(8'h60 + i[7:0]);
      rd(8'h04); chk("wrap", rdata, 32'h60 + i);
    end

    // unmapped read, read-only write
    rd(8'h0C); chk("unmapped", rdata, 32'd0);
    wr(8'h10, 32'h0);
    rd(8'h10);

    // reset mid-transfer
    push(8'hC1); push(8'hC2);
    wr(8'h08, 32'h77);
    chk("pre_rst_txv", {31'b0, tx_valid}, 32'd1);
    mid_reset();
    rd(8'h00); chk("post_rst_status", rdata, 32'h1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      logic [7:0] offs [8];
      offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
      offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'h18; offs[7] = $urandom_range(0, 255);
      sel = $urandom_range(0, 7);
      addr = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), offs[sel]};
      wdata = $urandom;
      io_recv = ($urandom_range(0, 2) == 0);
      io_trans = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if (sel == 6 && $urandom_range(0, 7) != 0) io_trans = 4'h0;
      inst_retired = $urandom_range(0, 1);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data = $urandom;
      tx_ready = ($urandom_range(0, 3) == 0);
      cycle();
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
